// File: rtl/vote_recorder.sv
// -----------------------------------------------------------------------------
// vote_recorder
//   Vote-capture front end of the EVM. The four raw candidate buttons are
//   synchronised through two flops and then debounced. The design accepts at
//   most one vote per press and keeps an 8-bit saturating tally for each
//   candidate.
//
//   Votes are accepted only when mode = 0 (voting mode). When mode = 1
//   (result mode) the tallies hold their values. A vote that has already
//   reached COMMIT still completes.
//
// Optional feature (macro VOTE_TOTAL_EN):
//   Adds the output total_votes, a 10-bit count of all accepted votes.
//   It increments together with valid_vote_casted.
//
// Ports
//   clock              in   system clock
//   reset              in   synchronous, active-high reset
//   mode               in   0 = voting, 1 = result
//   button1..button4   in   raw candidate buttons (async, active-high)
//   candidate1..4_vote out  8-bit per-candidate tallies
//   valid_vote_casted  out  one-cycle pulse per accepted vote
//   total_votes        out  10-bit accepted-vote total (VOTE_TOTAL_EN only)
// -----------------------------------------------------------------------------
module vote_recorder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DB_CNT_W        = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode,
  input  logic       button1,
  input  logic       button2,
  input  logic       button3,
  input  logic       button4,
  output logic [7:0] candidate1_vote,
  output logic [7:0] candidate2_vote,
  output logic [7:0] candidate3_vote,
  output logic [7:0] candidate4_vote,
`ifdef VOTE_TOTAL_EN
  output logic [9:0] total_votes,
`endif
  output logic       valid_vote_casted
);

  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_COMMIT,
    S_WAIT_RELEASE
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [3:0]          r_sync1;
  logic [3:0]          r_sync2;
  logic [3:0]          w_btn;
  logic                w_single;
  logic                w_multi;
  logic [1:0]          w_btn_idx;

  logic [1:0]          r_cand_idx;
  logic [3:0]          w_cand_oh;
  logic [DB_CNT_W-1:0] r_cnt;
  logic                r_armed;

  logic [7:0]          r_tally [4];
  logic                r_pulse;

  logic                w_capture;
  logic                w_cnt_inc;
  logic                w_accept;
  logic [7:0]          w_sel_tally;

  // Two-flop synchroniser; everything downstream sees only w_btn.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {button4, button3, button2, button1};
      r_sync2 <= r_sync1;
    end
  end

  assign w_btn     = r_sync2;
  assign w_single  = (w_btn != 4'b0000) && ((w_btn & (w_btn - 4'd1)) == 4'b0000);
  assign w_multi   = (w_btn != 4'b0000) && !w_single;
  assign w_cand_oh = 4'b0001 << r_cand_idx;

  always_comb begin
    w_btn_idx = 2'd0;
    case (w_btn)
      4'b0010: w_btn_idx = 2'd1;
      4'b0100: w_btn_idx = 2'd2;
      4'b1000: w_btn_idx = 2'd3;
      default: w_btn_idx = 2'd0;
    endcase
  end

  // Multi-press lockout. Once two or more buttons are seen together, no new
  // vote may start until every button has been released. Without this,
  // letting go of one button of a pair would turn the other, still-held
  // button into a vote without a fresh press.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_armed <= 1'b1;
    end else if (w_multi) begin
      r_armed <= 1'b0;
    end else if (w_btn == 4'b0000) begin
      r_armed <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!mode && w_single && r_armed) w_next = S_DEBOUNCE;
      end
      S_DEBOUNCE: begin
        if (mode || (w_btn != w_cand_oh)) w_next = S_IDLE;
        else if (r_cnt == DB_LAST)        w_next = S_COMMIT;
      end
      S_COMMIT:       w_next = S_WAIT_RELEASE;
      S_WAIT_RELEASE: begin
        if (w_btn == 4'b0000) w_next = S_IDLE;
      end
      default:        w_next = S_IDLE;
    endcase
  end

  // FSM output logic. A commit for a candidate already at 255 is swallowed:
  // there is no increment and no pulse.
  always_comb begin
    w_capture   = (r_state == S_IDLE) && (w_next == S_DEBOUNCE);
    w_cnt_inc   = (r_state == S_DEBOUNCE) && (w_next == S_DEBOUNCE);
    w_sel_tally = r_tally[r_cand_idx];
    w_accept    = (r_state == S_COMMIT) && (w_sel_tally != 8'hFF);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt      <= '0;
      r_cand_idx <= 2'd0;
    end else if (w_capture) begin
      r_cnt      <= '0;
      r_cand_idx <= w_btn_idx;
    end else if (w_cnt_inc) begin
      r_cnt      <= r_cnt + 1'b1;
    end
  end

  // Tally and pulse registers update on the same edge, so both become
  // visible in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) r_tally[i] <= 8'd0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= w_accept;
      if (w_accept) r_tally[r_cand_idx] <= w_sel_tally + 8'd1;
    end
  end

`ifdef VOTE_TOTAL_EN
  logic [9:0] r_total;

  always_ff @(posedge clock) begin
    if (reset)         r_total <= 10'd0;
    else if (w_accept) r_total <= r_total + 10'd1;
  end

  assign total_votes = r_total;
`endif

  assign candidate1_vote   = r_tally[0];
  assign candidate2_vote   = r_tally[1];
  assign candidate3_vote   = r_tally[2];
  assign candidate4_vote   = r_tally[3];
  assign valid_vote_casted = r_pulse;

endmodule

// File: doc/vote_recorder.md
Name: vote_recorder

Overview:
- Vote-capture front end of the EVM. It takes the four raw candidate push-buttons, synchronises and debounces them, and enforces one vote per press.
- It maintains the four 8-bit per-candidate tallies and emits a one-cycle valid_vote_casted pulse per accepted vote.
- Its tally and pulse outputs feed the downstream mode/LED display controller.
- Votes are only accepted in voting mode (mode=0). Tallies hold in result mode (mode=1).

Parameters:
- DEBOUNCE_CYCLES, 4, number of consecutive stable cycles a single press must persist before commit. Legal range 1..2^DB_CNT_W-1; deploy value ~1000000.
- DB_CNT_W, 20, width of the debounce counter.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- mode  input  1  0 = voting mode, 1 = result mode
- button1  input  1  raw candidate 1 button, asynchronous, active-high
- button2  input  1  raw candidate 2 button
- button3  input  1  raw candidate 3 button
- button4  input  1  raw candidate 4 button
- candidate1_vote  output  8  candidate 1 tally
- candidate2_vote  output  8  candidate 2 tally
- candidate3_vote  output  8  candidate 3 tally
- candidate4_vote  output  8  candidate 4 tally
- valid_vote_casted  output  1  one-cycle pulse per accepted vote

Behaviour:
- Reset values:
  - All tallies 0; valid_vote_casted 0.
  - FSM in IDLE; debounce counter 0; synchroniser flops 0.
- Reset mid-operation: discards any pending vote and clears all tallies.
- Synchroniser: each button passes through a 2-flop synchroniser. The FSM sees only the synchronised vector btn_s[3:0].
- "Single press": exactly one bit of btn_s is high.
- FSM states: IDLE, DEBOUNCE, COMMIT, WAIT_RELEASE.
- IDLE:
  - If mode=0 and single press: capture the candidate index, clear the counter, go to DEBOUNCE.
  - Otherwise stay in IDLE.
- DEBOUNCE:
  - If mode=1, or btn_s differs from the captured one-hot pattern (release, bounce, or a second button): go to IDLE, no vote.
  - Else if counter == DEBOUNCE_CYCLES-1: go to COMMIT.
  - Else increment the counter.
- COMMIT (one cycle; always completes, even if mode or buttons change):
  - On the exit edge, the captured tally increments by 1 and valid_vote_casted is registered high.
  - Both are visible in the same cycle; the pulse lasts exactly one cycle.
  - Next state is WAIT_RELEASE.
- WAIT_RELEASE: stay until btn_s == 0, then go to IDLE. A held button therefore never produces a second vote.
- Latency: with E0 as the first edge that samples the button high, the tally and pulse are visible after edge E(DEBOUNCE_CYCLES+3). For D=4, that is after E7, i.e. the 8th edge.
- Saturation:
  - A tally at 255 holds at 255; no wrap.
  - The COMMIT for a saturated candidate produces no valid_vote_casted pulse; the FSM still goes to WAIT_RELEASE.
- Simultaneous presses: two or more buttons high in IDLE means no transition. A second button arriving during DEBOUNCE aborts the vote.
- mode=1: tallies are held stable and no new vote starts. A vote already in COMMIT still completes.

Optional Feature:
- Macro: VOTE_TOTAL_EN.
- With the macro:
  - Extra output port total_votes (output, 10 bits) is the sum of accepted votes.
  - It increments exactly when valid_vote_casted pulses, so it stays consistent with the four tallies. Reset value 0.
- Without the macro: the port and its register do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle 20 cycles -> all tallies 0, valid_vote_casted never high.
- mode=0, DEBOUNCE_CYCLES=4, button2 high for 30 cycles -> candidate2_vote=1 after the 8th edge; exactly one 1-cycle pulse; the long hold gives no second vote.
- button3 high for 3 cycles, low, then high for 3 cycles (bounce shorter than debounce) -> no vote, tallies unchanged.
- button1 and button4 pressed together for 20 cycles -> no vote. Then release button4 only and hold button1 -> still no vote until button1 is released and pressed again, then candidate1_vote=1.
- mode=1 with button1 held 20 cycles -> no change. Switch mode to 1 during DEBOUNCE -> vote aborted.
- Cast 256 votes for candidate4 -> candidate4_vote=255; the 256th press gives no pulse. With VOTE_TOTAL_EN, total_votes=255; assert reset mid-DEBOUNCE -> all tallies 0 and no pulse.
